// File: rtl/reg_file_sequencer_if.sv
// Command handshake between a command source and the register-file sequencer.
// The master drives a command and the sequencer (slave) returns ready.
interface reg_file_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [7:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WB) sequencer executing one ALU command at a time
// against an external register file with combinational reads.
module reg_file_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    reg_file_sequencer_if.slave  cmd,
    output logic [1:0]           rf_port_a_sel,
    output logic [1:0]           rf_port_b_sel,
    input  logic [7:0]           rf_port_a_data,
    input  logic [7:0]           rf_port_b_data,
    output logic                 rf_write_en,
    output logic [1:0]           rf_write_sel,
    output logic [7:0]           rf_input_data,
    output logic                 done,
    output logic                 busy,
    output logic [7:0]           result,
    output logic                 flag_z,
    output logic                 flag_c
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpLdi = 3'b101,
        OpMov = 3'b110,
        OpCmp = 3'b111
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q;
    logic [1:0] rd_q, rs1_q, rs2_q;
    logic [7:0] imm_q;
    logic [7:0] a_q, b_q;
    logic [7:0] result_q;
    logic       flag_z_q, flag_c_q;

    logic       accept;
    logic [7:0] alu_res;
    logic       alu_c;
    logic [8:0] alu_sum;

    assign cmd.cmd_ready = (state_q == StIdle) && !reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_sum = {1'b0, a_q} + {1'b0, b_q};
        alu_res = 8'h00;
        alu_c   = 1'b0;
        unique case (op_q)
            OpAdd: begin
                alu_res = alu_sum[7:0];
                alu_c   = alu_sum[8];
            end
            OpSub, OpCmp: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q < b_q);
            end
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpXor: alu_res = a_q ^ b_q;
            OpLdi: alu_res = imm_q;
            OpMov: alu_res = a_q;
            default: alu_res = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            rd_q     <= 2'd0;
            rs1_q    <= 2'd0;
            rs2_q    <= 2'd0;
            imm_q    <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 8'h00;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_e'(cmd.cmd_op);
                rd_q  <= cmd.cmd_rd;
                rs1_q <= cmd.cmd_rs1;
                rs2_q <= cmd.cmd_rs2;
                imm_q <= cmd.cmd_imm;
            end
            if (state_q == StRead) begin
                a_q <= rf_port_a_data;
                b_q <= rf_port_b_data;
            end
            if (state_q == StExec) begin
                result_q <= alu_res;
                flag_c_q <= alu_c;
                flag_z_q <= (alu_res == 8'h00);
            end
        end
    end

    assign rf_port_a_sel = rs1_q;
    assign rf_port_b_sel = rs2_q;
    assign rf_write_sel  = rd_q;
    assign rf_input_data = result_q;

    // Reset gates WB so an aborted command neither writes nor signals completion.
    assign rf_write_en = (state_q == StWb) && (op_q != OpCmp) && !reset;
    assign done        = (state_q == StWb) && !reset;
    assign busy        = (state_q != StIdle);

    assign result = result_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer with a behavioural 4x8 register file.
module tb_reg_file_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] rf_port_a_sel, rf_port_b_sel;
    logic [7:0] rf_port_a_data, rf_port_b_data;
    logic       rf_write_en;
    logic [1:0] rf_write_sel;
    logic [7:0] rf_input_data;
    logic       done, busy, flag_z, flag_c;
    logic [7:0] result;

    logic [7:0] rf [4];
    int checks = 0;
    int fails  = 0;
    int accepts = 0;
    int acc_base;

    reg_file_sequencer_if cmd_if ();

    reg_file_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd_if),
        .rf_port_a_sel  (rf_port_a_sel),
        .rf_port_b_sel  (rf_port_b_sel),
        .rf_port_a_data (rf_port_a_data),
        .rf_port_b_data (rf_port_b_data),
        .rf_write_en    (rf_write_en),
        .rf_write_sel   (rf_write_sel),
        .rf_input_data  (rf_input_data),
        .done           (done),
        .busy           (busy),
        .result         (result),
        .flag_z         (flag_z),
        .flag_c         (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_port_a_data = rf[rf_port_a_sel];
    assign rf_port_b_data = rf[rf_port_b_sel];

    always @(posedge clk) begin
        if (rf_write_en) rf[rf_write_sel] <= rf_input_data;
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) accepts <= accepts + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        cmd_if.cmd_op  = op;
        cmd_if.cmd_rd  = rd;
        cmd_if.cmd_rs1 = rs1;
        cmd_if.cmd_rs2 = rs2;
        cmd_if.cmd_imm = imm;
    endtask

    // Issue one command and check every phase through WB and the return to IDLE.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [7:0] imm, input logic [7:0] exp_res,
                           input logic exp_c, input logic exp_z, input logic exp_we);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 10) begin
            step();
            n++;
        end
        chk({tag, ".ready"}, 8'(cmd_if.cmd_ready), 8'd1);
        drive(op, rd, rs1, rs2, imm);
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
        chk({tag, ".read_busy"}, 8'(busy), 8'd1);
        chk({tag, ".read_done"}, 8'(done), 8'd0);
        chk({tag, ".sel_a"}, 8'(rf_port_a_sel), 8'(rs1));
        chk({tag, ".sel_b"}, 8'(rf_port_b_sel), 8'(rs2));
        step();
        chk({tag, ".exec_done"}, 8'(done), 8'd0);
        chk({tag, ".exec_we"}, 8'(rf_write_en), 8'd0);
        step();
        chk({tag, ".wb_done"}, 8'(done), 8'd1);
        chk({tag, ".wb_we"}, 8'(rf_write_en), 8'(exp_we));
        chk({tag, ".wb_sel"}, 8'(rf_write_sel), 8'(rd));
        chk({tag, ".wb_data"}, rf_input_data, exp_res);
        step();
        chk({tag, ".post_done"}, 8'(done), 8'd0);
        chk({tag, ".post_ready"}, 8'(cmd_if.cmd_ready), 8'd1);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".flag_c"}, 8'(flag_c), 8'(exp_c));
        chk({tag, ".flag_z"}, 8'(flag_z), 8'(exp_z));
    endtask

    initial begin
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        drive(3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        step();
        step();
        chk("rst.ready", 8'(cmd_if.cmd_ready), 8'd0);
        chk("rst.we", 8'(rf_write_en), 8'd0);
        chk("rst.busy", 8'(busy), 8'd0);
        chk("rst.done", 8'(done), 8'd0);
        chk("rst.result", result, 8'h00);
        chk("rst.flag_z", 8'(flag_z), 8'd0);
        chk("rst.flag_c", 8'(flag_c), 8'd0);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", 8'(cmd_if.cmd_ready), 8'd1);

        run_cmd("ldi_aa", 3'b101, 2'd0, 2'd0, 2'd0, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b1);
        chk("ldi_aa.r0", rf[0], 8'hAA);

        run_cmd("ldi_f0", 3'b101, 2'd1, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1);
        run_cmd("ldi_20", 3'b101, 2'd2, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0, 1'b0, 1'b1);
        run_cmd("add", 3'b000, 2'd3, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 1'b0, 1'b1);
        chk("add.r3", rf[3], 8'h10);

        run_cmd("ldi_r1_20", 3'b101, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0, 1'b0, 1'b1);
        run_cmd("cmp", 3'b111, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("cmp.r0_kept", rf[0], 8'hAA);

        // Back-to-back with cmd_valid held high: LDI R0=05 then ADD R1=R0+R0.
        acc_base = accepts;
        drive(3'b101, 2'd0, 2'd0, 2'd0, 8'h05);
        cmd_if.cmd_valid = 1'b1;
        chk("b2b.ready0", 8'(cmd_if.cmd_ready), 8'd1);
        step();
        drive(3'b000, 2'd1, 2'd0, 2'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("b2b.not_ready", 8'(cmd_if.cmd_ready), 8'd0);
            step();
        end
        chk("b2b.ready4", 8'(cmd_if.cmd_ready), 8'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
        chk("b2b.r0", rf[0], 8'h05);
        step();
        step();
        chk("b2b.wb_done", 8'(done), 8'd1);
        chk("b2b.wb_data", rf_input_data, 8'h0A);
        step();
        chk("b2b.r1", rf[1], 8'h0A);
        chk("b2b.accepts", 8'(accepts - acc_base), 8'd2);

        // Reset during WB of LDI R2=77.
        drive(3'b101, 2'd2, 2'd0, 2'd0, 8'h77);
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("wbrst.we", 8'(rf_write_en), 8'd0);
        chk("wbrst.done", 8'(done), 8'd0);
        chk("wbrst.ready", 8'(cmd_if.cmd_ready), 8'd0);
        step();
        chk("wbrst.r2", rf[2], 8'h20);
        chk("wbrst.result", result, 8'h00);
        chk("wbrst.busy", 8'(busy), 8'd0);
        reset = 1'b0;
        #1;
        chk("wbrst.idle", 8'(cmd_if.cmd_ready), 8'd1);

        // Reset during READ discards the command with no done pulse.
        drive(3'b101, 2'd0, 2'd0, 2'd0, 8'h33);
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rdrst.no_done", 8'(done), 8'd0);
            step();
        end
        chk("rdrst.r0", rf[0], 8'h05);

        run_cmd("ldi_r1_10", 3'b101, 2'd1, 2'd0, 2'd0, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1);
        run_cmd("ldi_r2_30", 3'b101, 2'd2, 2'd0, 2'd0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b1);
        run_cmd("sub", 3'b001, 2'd1, 2'd1, 2'd2, 8'h00, 8'hE0, 1'b1, 1'b0, 1'b1);
        chk("sub.r1", rf[1], 8'hE0);

        run_cmd("and", 3'b010, 2'd3, 2'd1, 2'd2, 8'h00, 8'h20, 1'b0, 1'b0, 1'b1);
        run_cmd("or", 3'b011, 2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b1);
        run_cmd("xor", 3'b100, 2'd3, 2'd1, 2'd2, 8'h00, 8'hD0, 1'b0, 1'b0, 1'b1);
        chk("xor.r3", rf[3], 8'hD0);
        run_cmd("mov", 3'b110, 2'd0, 2'd1, 2'd2, 8'h00, 8'hE0, 1'b0, 1'b0, 1'b1);
        chk("mov.r0", rf[0], 8'hE0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sequencer.md
REG_FILE_SEQUENCER -- requirements
Module: reg_file_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port cmd_valid  input  1  command present.
REQ-004 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-005 SHALL have port cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI, 110 MOV, 111 CMP.
REQ-006 SHALL have ports cmd_rd, cmd_rs1, cmd_rs2  input  2 each  destination / source register indices.
REQ-007 SHALL have port cmd_imm  input  8  immediate value for LDI.
REQ-008 SHALL have ports rf_port_a_sel, rf_port_b_sel  output  2 each  register file read selects.
REQ-009 SHALL have ports rf_port_a_data, rf_port_b_data  input  8 each  combinational register file read data.
REQ-010 SHALL have ports rf_write_en  output  1, rf_write_sel  output  2, rf_input_data  output  8  register file write port.
REQ-011 SHALL have ports done  output  1  one-cycle completion pulse; busy  output  1  command in flight.
REQ-012 SHALL have ports result  output  8, flag_z  output  1, flag_c  output  1  last result and flags.

Function
REQ-013 SHALL implement FSM states IDLE, READ, EXEC, WB; transitions: IDLE->READ on accept, READ->EXEC, EXEC->WB, WB->IDLE, all unconditional except accept.
REQ-014 SHALL assert cmd_ready only in IDLE with reset low; accept = cmd_valid & cmd_ready; cmd_valid in other states is ignored and is not queued.
REQ-015 SHALL latch op, rd, rs1, rs2, imm on accept and hold them until the next accept.
REQ-016 SHALL drive rf_port_a_sel = latched rs1 and rf_port_b_sel = latched rs2 in every state.
REQ-017 SHALL capture rf_port_a_data / rf_port_b_data into operand registers A / B at the clock edge ending READ.
REQ-018 SHALL compute results at the clock edge ending EXEC:
- ADD: {C,R} = A+B (9-bit).
- SUB/CMP: R = A-B mod 256, C = 1 if A<B.
- AND/OR/XOR: R = bitwise op, C = 0.
- LDI: R = imm, C = 0.
- MOV: R = A, C = 0.
REQ-019 SHALL load result, flag_c, and flag_z = (R==0) at the EXEC-end edge, and hold them until the next EXEC.
REQ-020 SHALL, in WB, drive rf_write_en = 1 for exactly that cycle for all ops except CMP (CMP: 0), with rf_write_sel = latched rd and rf_input_data = result.
REQ-021 SHALL keep rf_write_en = 0 in all non-WB states; rf_write_sel and rf_input_data SHALL otherwise hold the latched rd and result.
REQ-022 SHALL assert done in the WB cycle only, including for CMP.
REQ-023 SHALL assert busy in READ, EXEC and WB.
REQ-024 SHALL give latency: accept at edge N -> done high in cycle N+3 -> register updated at the edge ending that cycle; cmd_ready high again in cycle N+4; throughput one command per 4 cycles.
REQ-025 SHALL make a command accepted right after WB read the register value just written (no hazard logic needed, because execution is serialized).
REQ-026 SHALL allow rd equal to rs1 and/or rs2; operands are the pre-write values.

Reset
REQ-027 SHALL, when reset is high at a clock edge, set the state to IDLE; A, B, result, flag_z, flag_c and latched fields to 0; and done and busy to 0.
REQ-028 SHALL gate rf_write_en and cmd_ready to 0 while reset is high, including when reset is asserted during WB, so an aborted command never writes.
REQ-029 SHALL, on reset asserted mid-operation (READ/EXEC), discard the command with no done pulse.

Verification
REQ-030 Reset, then LDI rd=0 imm=AA -> done at accept+3; R0=AA after that edge; flag_z=0; flag_c=0.
REQ-031 R1=F0, R2=20, ADD rd=3 rs1=1 rs2=2 -> result=10, flag_c=1, flag_z=0, R3=10.
REQ-032 R1=20, R2=20, CMP rs1=1 rs2=2 -> flag_z=1, flag_c=0, rf_write_en never high, done pulses.
REQ-033 cmd_valid held high with 2 commands back-to-back (LDI R0=05, then ADD R1=R0+R0) -> second accepted 4 cycles after the first; R1=0A; cmd_valid during busy accepted nothing.
REQ-034 Reset asserted during WB of LDI R2=77 -> rf_write_en=0 that cycle, no done pulse, state IDLE, result=00.
REQ-035 SUB rd=1 rs1=1 rs2=2 with R1=10, R2=30 -> R1=E0, flag_c=1 (borrow), flag_z=0.
